fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main control decoder.
- Holds the PC and drives the instruction-memory address. It latches the fetched word and PC+4 into IF/ID and exposes the latched opcode field to the decoder.
- Applies next-PC redirection for jumps and taken branches, and handles stall, flush and memory wait.

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, and latches the
// fetched word with its PC+4 for the decoder. Jumps and taken branches
// redirect the PC; stall, flush and memory wait control the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        flush,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc4,
    input  logic [15:0] branch_offset,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [31:0] fetch_count
);

    // IF/ID occupancy: EMPTY holds a bubble, FULL holds a real instruction.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4_s;
    logic [31:0] jump_target_s;
    logic [31:0] branch_target_s;
    logic        fetch_ok_s;

    // Sequential PC wrap from 32'hFFFF_FFFC to 0 falls out of the 32-bit add.
    assign pc_plus4_s      = pc_q + 32'd4;
    // Jump target takes its region bits from the jump's own PC+4, held in IF/ID.
    assign jump_target_s   = {pc4_q[31:28], jump_index, 2'b00};
    assign branch_target_s = branch_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    // A word is consumed only when memory delivers it and nothing holds the PC.
    assign fetch_ok_s      = imem_ready & ~stall;

    // State register: PC, IF/ID contents and fetch counter, async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: redirect > stall > memory wait > normal fetch, with
    // flush turning whatever IF/ID would latch into a bubble.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        count_d = count_q;

        if (jump) begin
            pc_d    = jump_target_s;
            state_d = EMPTY;
            instr_d = NOP_WORD;
            pc4_d   = 32'h0000_0000;
        end else if (branch_taken) begin
            pc_d    = branch_target_s;
            state_d = EMPTY;
            instr_d = NOP_WORD;
            pc4_d   = 32'h0000_0000;
        end else if (stall) begin
            // PC frozen; IF/ID holds unless flush kills it.
            pc_d = pc_q;
            if (flush) begin
                state_d = EMPTY;
                instr_d = NOP_WORD;
                pc4_d   = 32'h0000_0000;
            end else begin
                state_d = state_q;
            end
        end else if (!fetch_ok_s) begin
            // Memory wait: PC holds and a bubble enters IF/ID.
            pc_d    = pc_q;
            state_d = EMPTY;
            instr_d = NOP_WORD;
            pc4_d   = 32'h0000_0000;
        end else begin
            pc_d = pc_plus4_s;
            if (flush) begin
                // Fetched word is discarded and not counted.
                state_d = EMPTY;
                instr_d = NOP_WORD;
                pc4_d   = 32'h0000_0000;
            end else begin
                state_d = FULL;
                instr_d = imem_rdata;
                pc4_d   = pc_plus4_s;
                count_d = count_q + 32'd1;
            end
        end
    end

    // Output logic: all outputs come straight from registers.
    always_comb begin
        imem_addr   = pc_q;
        if_id_instr = instr_q;
        if_id_pc4   = pc4_q;
        if_id_valid = (state_q == FULL);
        opcode      = instr_q[31:26];
        fetch_count = count_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// stimulus, all checked through a scoreboard fed by a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        flush;
    logic        jump;
    logic [25:0] jump_index;
    logic        branch_taken;
    logic [31:0] branch_pc4;
    logic [15:0] branch_offset;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .stall(stall), .flush(flush), .jump(jump),
        .jump_index(jump_index), .branch_taken(branch_taken),
        .branch_pc4(branch_pc4), .branch_offset(branch_offset),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .opcode(opcode), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2008_0005;
        if (a == 32'h0000_0004) return 32'h2009_0003;
        return (a * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    // instruction memory: combinational read of the current address
    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_0000; m_instr = 32'h0000_0000; m_pc4 = 32'h0000_0000;
        m_valid = 1'b0; m_count = 32'h0000_0000;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0000_0000; m_pc4 = 32'h0000_0000; m_valid = 1'b0;
    endtask

    // Behavioural model of one clock edge, pushed as an expectation.
    task automatic model_step();
        exp_t e;
        logic [31:0] word;
        logic        takes_word;
        logic        keeps_ifid;
        int          off;
        if (jump) begin
            m_pc = {m_pc4[31:28], jump_index, 2'b00};
            model_bubble();
        end else if (branch_taken) begin
            off  = int'($signed(branch_offset));
            m_pc = branch_pc4 + 32'(off * 4);
            model_bubble();
        end else begin
            takes_word = imem_ready && !stall;
            keeps_ifid = stall && !flush;
            word = mem_word(m_pc);
            if (takes_word && !flush) begin
                m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end else if (!keeps_ifid) begin
                model_bubble();
            end
            if (takes_word) m_pc = m_pc + 32'd4;
        end
        e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.count = m_count;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and record the expectation.
    task automatic cycle(input logic j, input logic [25:0] ji, input logic b,
                         input logic [31:0] bp4, input logic [15:0] bo,
                         input logic st, input logic fl, input logic rdy);
        jump = j; jump_index = ji; branch_taken = b; branch_pc4 = bp4;
        branch_offset = bo; stall = st; flush = fl; imem_ready = rdy;
        model_step();
        @(negedge clk);
    endtask

    task automatic fetch1();
        cycle(1'b0, 26'd0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every cycle with a pending expectation, compare DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_addr",  imem_addr,   e.addr);
                check("sb_instr", if_id_instr, e.instr);
                check("sb_pc4",   if_id_pc4,   e.pc4);
                check("sb_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                check("sb_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
                check("sb_count", fetch_count, e.count);
            end
        end
    end

    initial begin
        rst = 1'b1; jump = 1'b0; jump_index = 26'd0; branch_taken = 1'b0;
        branch_pc4 = 32'd0; branch_offset = 16'd0; stall = 1'b0; flush = 1'b0;
        imem_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_addr",  imem_addr, 32'h0000_0000);
        check("reset_valid", {31'd0, if_id_valid}, 32'd0);
        check("reset_count", fetch_count, 32'd0);

        // first fetches
        fetch1();
        check("first_instr",  if_id_instr, 32'h2008_0005);
        check("first_pc4",    if_id_pc4, 32'h0000_0004);
        check("first_opcode", {26'd0, opcode}, 32'h0000_0008);
        check("first_addr",   imem_addr, 32'h0000_0004);
        fetch1();
        check("second_count", fetch_count, 32'd2);
        check("second_addr",  imem_addr, 32'h0000_0008);

        // stall for three cycles
        repeat (3) cycle(1'b0, 26'd0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        check("stall_instr", if_id_instr, 32'h2009_0003);
        check("stall_addr",  imem_addr, 32'h0000_0008);
        check("stall_count", fetch_count, 32'd2);
        fetch1();
        fetch1();
        check("pre_jump_pc4", if_id_pc4, 32'h0000_0010);

        // jump with stall asserted
        cycle(1'b1, 26'h000_0040, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        check("jump_addr",  imem_addr, 32'h0000_0100);
        check("jump_valid", {31'd0, if_id_valid}, 32'd0);
        check("jump_instr", if_id_instr, 32'h0000_0000);
        fetch1();
        check("after_jump_pc4", if_id_pc4, 32'h0000_0104);

        // branches and jump-over-branch priority
        cycle(1'b0, 26'd0, 1'b1, 32'h0000_0020, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        check("branch_neg", imem_addr, 32'h0000_0018);
        cycle(1'b0, 26'd0, 1'b1, 32'h0000_0020, 16'h0003, 1'b0, 1'b0, 1'b1);
        check("branch_pos", imem_addr, 32'h0000_002C);
        cycle(1'b1, 26'h000_0080, 1'b1, 32'h0000_0020, 16'h0003, 1'b0, 1'b0, 1'b1);
        check("jump_wins", imem_addr, 32'h0000_0200);

        // memory wait
        repeat (2) cycle(1'b0, 26'd0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        check("wait_addr",  imem_addr, 32'h0000_0200);
        check("wait_valid", {31'd0, if_id_valid}, 32'd0);
        fetch1();
        check("wait_count", fetch_count, 32'd6);

        // flush under stall: pc holds, IF/ID bubbles
        cycle(1'b0, 26'd0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        check("flush_stall_addr",  imem_addr, 32'h0000_0204);
        check("flush_stall_valid", {31'd0, if_id_valid}, 32'd0);

        // move to 0x3C, fetch so IF/ID is FULL at pc=0x40, then async reset
        cycle(1'b1, 26'h000_000F, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        fetch1();
        check("pre_rst_addr", imem_addr, 32'h0000_0040);
        #2;
        rst = 1'b1;
        #1;
        check("async_addr",  imem_addr, 32'h0000_0000);
        check("async_instr", if_id_instr, 32'h0000_0000);
        check("async_pc4",   if_id_pc4, 32'h0000_0000);
        check("async_valid", {31'd0, if_id_valid}, 32'd0);
        check("async_count", fetch_count, 32'd0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // PC wrap
        cycle(1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        fetch1();
        check("wrap_addr",  imem_addr, 32'h0000_0000);
        check("wrap_pc4",   if_id_pc4, 32'h0000_0000);
        check("wrap_valid", {31'd0, if_id_valid}, 32'd1);

        // random stimulus
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(15) == 0), 26'($urandom),
                  ($urandom_range(7) == 0), {$urandom_range(32'h3FFF_FFFF), 2'b00},
                  16'($urandom), ($urandom_range(3) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(3) != 0));
        end

        // drain scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
